// File: rtl/stage3_infer_ctrl.sv
// Frame sequencer for the stage-3 classifier: gates N_BEATS ReLU beats, then waits for a result or times out.
// Beat path has 1-cycle registered latency; the result FIFO is first-word-fall-through and drops pushes when full.
module stage3_infer_ctrl #(
  parameter int         IN_W       = 16,
  parameter int         N_BEATS    = 36,
  parameter int         TIMEOUT    = 64,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ERR_CHAR   = 8'h3F
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_start,
  output logic            o_busy,
  input  logic            i_relu_valid,
  input  logic [IN_W-1:0] i_relu_data,
  output logic            o_cnn_valid,
  output logic [IN_W-1:0] o_cnn_data,
  input  logic            i_cnn_valid,
  input  logic [7:0]      i_cnn_alpha,
  output logic            o_char_valid,
  output logic [7:0]      o_char,
  input  logic            i_char_ready,
  output logic            o_timeout,
  output logic            o_drop
);

  localparam int BW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FEED, WAIT} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            push;
  logic [7:0]      push_char;
  logic            timeout_hit;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full, fifo_empty, pop, wr_en;

  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    push_char   = ERR_CHAR;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: if (i_start) state_d = FEED;
      FEED: if (i_relu_valid && beat_cnt == LAST_BEAT) state_d = WAIT;
      WAIT: begin
        // A result arriving in the final wait cycle still beats the timeout.
        if (i_cnn_valid) begin
          push      = 1'b1;
          push_char = i_cnn_alpha;
          state_d   = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          push        = 1'b1;
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= IDLE;
      beat_cnt    <= '0;
      wait_cnt    <= '0;
      o_cnn_valid <= 1'b0;
      o_cnn_data  <= '0;
      o_timeout   <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_cnn_valid <= (state_q == FEED) && i_relu_valid;
      o_timeout   <= timeout_hit;
      if (state_q == FEED) o_cnn_data <= i_relu_data;
      if (state_q == IDLE && i_start) beat_cnt <= '0;
      else if (state_q == FEED && i_relu_valid) beat_cnt <= beat_cnt + BW'(1);
      if (state_q == FEED) wait_cnt <= '0;
      else if (state_q == WAIT) wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign o_busy = (state_q != IDLE);

  // Result queue: runs independently of the FSM so a stalled consumer never blocks a frame.
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_CNT);
  assign pop          = !fifo_empty && i_char_ready;
  assign wr_en        = push && (!fifo_full || pop);
  assign o_char_valid = !fifo_empty;
  assign o_char       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_drop <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      o_drop <= push && fifo_full && !pop;
      if (wr_en) begin
        mem[wr_ptr] <= push_char;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_stage3_infer_ctrl.sv
// Randomized bench for stage3_infer_ctrl against a frame-level model: beat forwarding, result/timeout selection, and a bounded char queue.
module tb_stage3_infer_ctrl;

  localparam int         IN_W     = 16;
  localparam int         N_BEATS  = 36;
  localparam int         TIMEOUT  = 64;
  localparam int         DEPTH    = 4;
  localparam logic [7:0] ERR_CHAR = 8'h3F;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            i_start = 1'b0;
  logic            o_busy;
  logic            i_relu_valid = 1'b0;
  logic [IN_W-1:0] i_relu_data = '0;
  logic            o_cnn_valid;
  logic [IN_W-1:0] o_cnn_data;
  logic            i_cnn_valid = 1'b0;
  logic [7:0]      i_cnn_alpha = '0;
  logic            o_char_valid;
  logic [7:0]      o_char;
  logic            i_char_ready = 1'b0;
  logic            o_timeout;
  logic            o_drop;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_q[$];

  stage3_infer_ctrl #(
    .IN_W(IN_W), .N_BEATS(N_BEATS), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH), .ERR_CHAR(ERR_CHAR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_busy(o_busy),
    .i_relu_valid(i_relu_valid), .i_relu_data(i_relu_data),
    .o_cnn_valid(o_cnn_valid), .o_cnn_data(o_cnn_data),
    .i_cnn_valid(i_cnn_valid), .i_cnn_alpha(i_cnn_alpha),
    .o_char_valid(o_char_valid), .o_char(o_char), .i_char_ready(i_char_ready),
    .o_timeout(o_timeout), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One frame: start, nbeats beats, result at WAIT cycle 'resp' (negative or too late means timeout).
  task automatic run_inference(input int nbeats, input int resp, input logic [7:0] alpha,
                               input bit gaps, input bit pop_on_resp, input bit noisy);
    int fwd, k, sent;
    bit in_wait, was_wait, was_beat, exp_v, respond, end_now, exp_drop;
    logic [IN_W-1:0] d;
    logic [7:0] exp_ch;
    fwd = 0; k = 0; sent = 0; in_wait = 0;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", o_busy); end
    while (sent < nbeats) begin
      if (noisy) begin
        i_start     = 1'($urandom_range(0, 1));
        i_cnn_valid = !in_wait && ($urandom_range(0, 1) == 1);
      end
      d = IN_W'($urandom);
      i_relu_data = d;
      if (gaps && !in_wait && $urandom_range(0, 3) == 0) begin
        i_relu_valid = 1'b0;
        exp_v = 1'b0;
      end else begin
        i_relu_valid = 1'b1;
        exp_v = !in_wait;
        sent++;
      end
      was_beat = i_relu_valid;
      was_wait = in_wait;
      tick;
      n_checks++;
      if (o_cnn_valid !== exp_v) begin n_fail++; $display("FAIL cnn_valid beat %0d: got %b want %b", sent, o_cnn_valid, exp_v); end
      if (exp_v) begin
        n_checks++;
        if (o_cnn_data !== d) begin n_fail++; $display("FAIL cnn_data beat %0d: got %h want %h", sent, o_cnn_data, d); end
      end
      n_checks++;
      if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_feed: got %b want 1", o_busy); end
      if (was_wait) k++;
      else if (was_beat) begin
        fwd++;
        if (fwd == N_BEATS) in_wait = 1'b1;
      end
    end
    i_relu_valid = 1'b0;
    i_cnn_valid  = 1'b0;
    for (int g = 0; g < TIMEOUT + 2; g++) begin
      respond = (resp >= 0) && (k == resp);
      end_now = respond || (k == TIMEOUT - 1);
      i_cnn_valid  = respond;
      i_cnn_alpha  = respond ? alpha : 8'($urandom);
      i_char_ready = end_now && pop_on_resp;
      i_relu_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) i_start = 1'($urandom_range(0, 1));
      tick;
      n_checks++;
      if (o_cnn_valid !== 1'b0) begin n_fail++; $display("FAIL cnn_valid_wait k=%0d: got %b want 0", k, o_cnn_valid); end
      if (end_now) begin
        exp_ch = respond ? alpha : ERR_CHAR;
        if (pop_on_resp && model_q.size() > 0) void'(model_q.pop_front());
        exp_drop = (model_q.size() >= DEPTH);
        if (!exp_drop) model_q.push_back(exp_ch);
        n_checks++;
        if (o_timeout !== !respond) begin n_fail++; $display("FAIL timeout_pulse: got %b want %b", o_timeout, !respond); end
        n_checks++;
        if (o_drop !== exp_drop) begin n_fail++; $display("FAIL drop_pulse: got %b want %b", o_drop, exp_drop); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_end: got %b want 0", o_busy); end
        n_checks++;
        if (o_char_valid !== 1'b1 || o_char !== model_q[0]) begin
          n_fail++; $display("FAIL head_after_push: got v=%b %h want v=1 %h", o_char_valid, o_char, model_q[0]);
        end
        break;
      end
      n_checks++;
      if (o_busy !== 1'b1 || o_timeout !== 1'b0) begin
        n_fail++; $display("FAIL wait_state k=%0d: got busy=%b to=%b want busy=1 to=0", k, o_busy, o_timeout);
      end
      k++;
    end
    i_cnn_valid = 1'b0; i_start = 1'b0; i_char_ready = 1'b0; i_relu_valid = 1'b0;
    tick;
    n_checks++;
    if (o_timeout !== 1'b0 || o_drop !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL post_frame: got to=%b drop=%b busy=%b want 0 0 0", o_timeout, o_drop, o_busy);
    end
    n_checks++;
    if (o_char_valid !== (model_q.size() > 0)) begin
      n_fail++; $display("FAIL post_frame_valid: got %b want %b", o_char_valid, model_q.size() > 0);
    end
  endtask

  task automatic drain(input bit random_ready);
    for (int g = 0; g < 200 && model_q.size() > 0; g++) begin
      i_char_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n_checks++;
      if (o_char_valid !== 1'b1 || o_char !== model_q[0]) begin
        n_fail++; $display("FAIL drain_head: got v=%b %h want v=1 %h", o_char_valid, o_char, model_q[0]);
      end
      tick;
      if (i_char_ready) void'(model_q.pop_front());
    end
    i_char_ready = 1'b0;
    n_checks++;
    if (o_char_valid !== 1'b0 || model_q.size() != 0) begin
      n_fail++; $display("FAIL drain_empty: got v=%b left=%0d want v=0 left=0", o_char_valid, model_q.size());
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    tick;
    tick;
    n_checks++;
    if (o_busy !== 1'b0 || o_cnn_valid !== 1'b0 || o_cnn_data !== '0) begin
      n_fail++; $display("FAIL reset_fsm: got busy=%b cv=%b cd=%h want 0 0 0", o_busy, o_cnn_valid, o_cnn_data);
    end
    n_checks++;
    if (o_char_valid !== 1'b0 || o_char !== 8'h00 || o_timeout !== 1'b0 || o_drop !== 1'b0) begin
      n_fail++; $display("FAIL reset_fifo: got v=%b ch=%h to=%b drop=%b want 0 00 0 0", o_char_valid, o_char, o_timeout, o_drop);
    end
    reset_n = 1'b0;
    model_q.delete();
    tick;
  endtask

  task automatic test_single;
    run_inference(N_BEATS, 5, 8'h62, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_extra_beats;
    run_inference(N_BEATS + 4, 10, 8'h61, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_timeout;
    run_inference(N_BEATS, -1, 8'h00, 1'b1, 1'b0, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_fifo_full;
    logic [7:0] seq [5];
    seq = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62};
    foreach (seq[i]) run_inference(N_BEATS, $urandom_range(0, 20), seq[i], 1'b0, 1'b0, 1'b0);
    drain(1'b1);
  endtask

  task automatic test_push_pop_full;
    logic [7:0] seq [4];
    seq = '{8'h61, 8'h62, 8'h63, 8'h61};
    foreach (seq[i]) run_inference(N_BEATS, $urandom_range(0, 10), seq[i], 1'b1, 1'b0, 1'b0);
    run_inference(N_BEATS, 3, 8'h62, 1'b0, 1'b1, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_reset_midframe;
    run_inference(N_BEATS, 2, 8'h63, 1'b0, 1'b0, 1'b0);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    for (int b = 0; b < 19; b++) begin
      i_relu_valid = 1'b1;
      i_relu_data  = IN_W'($urandom);
      tick;
    end
    i_relu_data = IN_W'($urandom);
    reset_n = 1'b1;
    tick;
    reset_n = 1'b0;
    i_relu_valid = 1'b0;
    model_q.delete();
    n_checks++;
    if (o_busy !== 1'b0 || o_cnn_valid !== 1'b0 || o_cnn_data !== '0 || o_char_valid !== 1'b0 ||
        o_char !== 8'h00 || o_timeout !== 1'b0 || o_drop !== 1'b0) begin
      n_fail++; $display("FAIL midframe_reset: got busy=%b cv=%b cd=%h v=%b ch=%h to=%b drop=%b want all 0",
                         o_busy, o_cnn_valid, o_cnn_data, o_char_valid, o_char, o_timeout, o_drop);
    end
    i_cnn_valid = 1'b1;
    i_cnn_alpha = 8'h63;
    tick;
    i_cnn_valid = 1'b0;
    tick;
    n_checks++;
    if (o_char_valid !== 1'b0 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL late_result_idle: got v=%b busy=%b to=%b want 0 0 0", o_char_valid, o_busy, o_timeout);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      run_inference(N_BEATS + $urandom_range(0, 3), $urandom_range(3, TIMEOUT + 6), 8'($urandom),
                    1'b1, 1'($urandom_range(0, 1)), 1'b1);
      if (n % 3 == 2) drain(1'b1);
    end
    drain(1'b1);
  endtask

  initial begin
    test_reset;
    test_single;
    test_extra_beats;
    test_timeout;
    test_fifo_full;
    test_push_pop_full;
    test_reset_midframe;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
